fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, prefetch buffer entries (power of two, ≥2).
REQ-002 SHALL have parameter AW, default 8, instruction-ROM address width.
REQ-003 SHALL have port Clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset. One clock; reset is synchronous and active-high.
REQ-005 SHALL have port Enable, input, 1, permits new ROM reads when high.
REQ-006 SHALL have port Redirect, input, 1, branch/jump taken; flush and restart at RedirectAddr.
REQ-007 SHALL have port RedirectAddr, input, 16, new fetch PC.
REQ-008 SHALL have port RomAddr, output, AW, address to synchronous instruction ROM (1-cycle read latency).
REQ-009 SHALL have port RomData, input, 16, ROM read data, valid the cycle after RomAddr is sampled.
REQ-010 SHALL have port Instr, output, 16, head-of-buffer instruction word.
REQ-011 SHALL have port InstrPC, output, 16, PC of the word on Instr.
REQ-012 SHALL have port InstrValid, output, 1, Instr/InstrPC valid.
REQ-013 SHALL have port InstrReady, input, 1, consumer accepts head word; a pop occurs when InstrValid and InstrReady are both high.

Function
REQ-014 SHALL hold a 16-bit fetch PC; RomAddr SHALL equal PC[AW-1:0] combinationally.
REQ-015 SHALL issue a read in a cycle iff Enable=1, Redirect=0, and count + inflight − pop < DEPTH; on issue, PC increments by 1, wrapping 0xFFFF→0x0000.
REQ-016 SHALL tag each issued read with its PC in a one-deep in-flight register; the returning RomData SHALL be written with that tag into the FIFO at the end of the following cycle.
REQ-017 Latency: issue in cycle n -> InstrValid=1 with that word in cycle n+2; sustained throughput of one word per cycle when InstrReady is held high.
REQ-018 The FIFO SHALL be in-order; pointers wrap modulo DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-019 Full: no read is issued while count + inflight − pop = DEPTH; the FIFO never overflows, and no returning word is dropped.
REQ-020 Empty: InstrValid=0; Instr and InstrPC hold their last values; a pop is ignored.
REQ-021 State machine states: IDLE (Enable=0 or just reset), FETCH (issuing), HOLD (buffer full).
REQ-022 Transitions: IDLE→FETCH on Enable; FETCH→HOLD when the issue condition is false for full; HOLD→FETCH on pop; any state→IDLE when Enable falls. Buffered words SHALL remain poppable in IDLE.
REQ-023 Redirect SHALL have priority over all else: in the same edge, clear the FIFO, drop the in-flight word, set PC to RedirectAddr, and issue no read. The first read from the new PC issues in the next cycle.
REQ-024 A pop coincident with Redirect SHALL count as accepted; that word is consumed, and all others are flushed.
REQ-025 Redirect while Enable=0 SHALL update PC and flush; no read is issued until Enable is high.

Reset
REQ-026 Reset=1 at an edge SHALL set PC=0x0000, count=0, inflight=0, FIFO pointers=0, state=IDLE, InstrValid=0, Instr=0x0000, and InstrPC=0x0000.
REQ-027 Reset SHALL override Redirect and Enable; a mid-operation reset SHALL discard buffered and in-flight words, and RomData in the following cycle SHALL be ignored.

Structure
REQ-028 The shared package SHALL hold the state enum (IDLE/FETCH/HOLD), the 16-bit word width, and the default DEPTH/AW constants.
REQ-029 The FIFO storage with its pointers and count SHALL be one sub-module, fetch_fifo. The PC, in-flight tag and FSM SHALL live in fetch_unit.

Verification
REQ-030 Scenario 1: reset, then Enable=1 with InstrReady=1, ROM[a]=a+0x100 -> from cycle 2 on, InstrValid=1 every cycle, with InstrPC 0,1,2... and Instr 0x0100,0x0101,...
REQ-031 Scenario 2: InstrReady=0 for 10 cycles -> exactly 2 reads issued, InstrValid=1 holding PC 0; release -> words for PCs 0,1,2 in order, none lost or duplicated.
REQ-032 Scenario 3: Redirect to 0x0040 with one word in flight and two buffered -> InstrValid=0 for 2 cycles, then InstrPC=0x0040; no stale word appears.
REQ-033 Scenario 4: PC=0xFFFF, stream 3 words -> InstrPC sequence 0xFFFF,0x0000,0x0001, with RomAddr 0xFF,0x00,0x01.
REQ-034 Scenario 5: Reset asserted with a full buffer and a read in flight -> the next cycle shows InstrValid=0 and PC=0, and the first word after release is PC 0.
REQ-035 Scenario 6: pop coincides with Redirect to 0x0010 -> the popped word is counted once, and the next valid word has InstrPC=0x0010.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package fetch_pkg;

    localparam int WORD_W    = 16;
    localparam int DEPTH_DEF = 2;
    localparam int AW_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer. The head word is registered and holds its last value
// when the buffer drains or is flushed.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output fetch_entry_t           head_entry
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    fetch_entry_t  head_q, head_d;
    logic          do_pop_s;

    // Next buffer contents; a flush discards everything, including a same-cycle push.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop_s = pop && (count_q != '0);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(push) - CW'(do_pop_s);
        end
        valid_d = (count_d != '0);
        if (valid_d) begin
            head_d = mem_d[rd_ptr_d];
        end else begin
            head_d = head_q;
        end
    end

    // Buffer state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    assign count      = count_q;
    assign head_valid = valid_q;
    assign head_entry = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-deep in-flight tag for a 1-cycle synchronous ROM,
// and a small prefetch buffer toward the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Redirect,
    input  logic [WORD_W-1:0] RedirectAddr,
    output logic [AW-1:0]     RomAddr,
    input  logic [WORD_W-1:0] RomData,
    output logic [WORD_W-1:0] Instr,
    output logic [WORD_W-1:0] InstrPC,
    output logic              InstrValid,
    input  logic              InstrReady
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_L = DEPTH[CW:0];

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [WORD_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [CW-1:0]     fifo_count_s;
    logic              fifo_valid_s;
    fetch_entry_t      head_s;
    fetch_entry_t      push_entry_s;
    logic              pop_s, push_s, issue_s, room_s;
    logic [CW:0]       occ_s;

    assign pop_s        = fifo_valid_s && InstrReady;
    assign push_s       = inflight_q && !Redirect;
    assign push_entry_s = '{pc: inflight_pc_q, instr: RomData};

    // Occupancy counts the word still in the ROM pipe, so the buffer can never overflow.
    always_comb begin
        occ_s  = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_s};
        room_s = (occ_s < DEPTH_L);
    end

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (!Enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_FETCH;
                ST_FETCH: state_d = (!room_s && !Redirect) ? ST_HOLD : ST_FETCH;
                ST_HOLD:  state_d = (pop_s || Redirect) ? ST_FETCH : ST_HOLD;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs; the first Enable cycle out of IDLE already issues.
    always_comb begin
        case (state_q)
            ST_IDLE, ST_FETCH, ST_HOLD: issue_s = Enable && !Redirect && room_s;
            default:                    issue_s = 1'b0;
        endcase
    end

    // PC and in-flight tag; a redirect replaces the PC and drops the outstanding read.
    always_comb begin
        if (Redirect) begin
            pc_d = RedirectAddr;
        end else if (issue_s) begin
            pc_d = pc_q + 16'd1;
        end else begin
            pc_d = pc_q;
        end
        inflight_d = issue_s;
        if (issue_s) begin
            inflight_pc_d = pc_q;
        end else begin
            inflight_pc_d = inflight_pc_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q          <= 16'h0000;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 16'h0000;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (Clock),
        .rst        (Reset),
        .flush      (Redirect),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .count      (fifo_count_s),
        .head_valid (fifo_valid_s),
        .head_entry (head_s)
    );

    assign RomAddr    = pc_q[AW-1:0];
    assign Instr      = head_s.instr;
    assign InstrPC    = head_s.pc;
    assign InstrValid = fifo_valid_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam int AW    = 8;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        Redirect;
    logic [15:0] RedirectAddr;
    logic [7:0]  RomAddr;
    logic [15:0] RomData;
    logic [15:0] Instr;
    logic [15:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Model state: buffered PCs, PCs in the ROM pipe, fetch PC, displayed word.
    logic [15:0] q_buf[$];
    logic [15:0] q_fly[$];
    logic [15:0] m_pc;
    logic [15:0] m_last_pc;
    logic [15:0] m_last_instr;
    int          model_pops;
    int          obs_pops;

    always #5 Clock = ~Clock;

    // Synchronous ROM, ROM[a] = a + 0x100.
    always @(posedge Clock) RomData <= 16'h0100 + {8'h00, RomAddr};

    fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Enable       (Enable),
        .Redirect     (Redirect),
        .RedirectAddr (RedirectAddr),
        .RomAddr      (RomAddr),
        .RomData      (RomData),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady)
    );

    function automatic logic [15:0] rom_val(input logic [15:0] pc);
        return 16'h0100 + {8'h00, pc[7:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at negedge, advance model across posedge, compare at next negedge.
    task automatic step(input logic rst, input logic en, input logic rd,
                        input logic [15:0] ra, input logic rdy);
        bit pop;
        bit issue;
        int occ;
        Reset        = rst;
        Enable       = en;
        Redirect     = rd;
        RedirectAddr = ra;
        InstrReady   = rdy;
        if (!rst && InstrValid && rdy) obs_pops++;
        pop   = (q_buf.size() > 0) && rdy;
        occ   = q_buf.size() + q_fly.size() - (pop ? 1 : 0);
        issue = en && !rd && (occ < DEPTH);
        @(posedge Clock);
        if (rst) begin
            q_buf.delete();
            q_fly.delete();
            m_pc         = 16'h0000;
            m_last_pc    = 16'h0000;
            m_last_instr = 16'h0000;
        end else begin
            if (pop) begin
                void'(q_buf.pop_front());
                model_pops++;
            end
            if (rd) begin
                q_buf.delete();
                q_fly.delete();
                m_pc = ra;
            end else begin
                if (q_fly.size() > 0) q_buf.push_back(q_fly.pop_front());
                if (issue) begin
                    q_fly.push_back(m_pc);
                    m_pc = m_pc + 16'd1;
                end
            end
            if (q_buf.size() > 0) begin
                m_last_pc    = q_buf[0];
                m_last_instr = rom_val(q_buf[0]);
            end
        end
        @(negedge Clock);
        check_eq("valid",   32'(InstrValid), 32'(q_buf.size() > 0));
        check_eq("instrpc", 32'(InstrPC),    32'(m_last_pc));
        check_eq("instr",   32'(Instr),      32'(m_last_instr));
        check_eq("romaddr", 32'(RomAddr),    32'(m_pc[7:0]));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
        model_pops = 0;
        obs_pops   = 0;
    endtask

    initial begin
        logic [15:0] popped_pc;
        Reset = 1'b1; Enable = 1'b0; Redirect = 1'b0; RedirectAddr = 16'h0000; InstrReady = 1'b0;
        model_pops = 0;
        obs_pops   = 0;
        @(negedge Clock);

        // Reset state
        do_reset();
        check_eq("rst_valid", 32'(InstrValid), 32'd0);
        check_eq("rst_pc",    32'(InstrPC),    32'h0000);
        check_eq("rst_instr", 32'(Instr),      32'h0000);
        check_eq("rst_addr",  32'(RomAddr),    32'h00);

        // Scenario 1: streaming
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
            if (i >= 1) begin
                check_eq("s1_valid", 32'(InstrValid), 32'd1);
                check_eq("s1_pc",    32'(InstrPC),    32'(i - 1));
                check_eq("s1_instr", 32'(Instr),      32'(16'h0100 + 16'(i - 1)));
            end
        end

        // Scenario 2: consumer stall, then release
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("s2_reads", 32'(RomAddr),    32'd2);
        check_eq("s2_valid", 32'(InstrValid), 32'd1);
        check_eq("s2_head",  32'(InstrPC),    32'h0000);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
            check_eq("s2_order", 32'(InstrPC), 32'(k));
        end

        // Scenario 3: redirect with buffered and in-flight words
        step(1'b0, 1'b1, 1'b1, 16'h0040, 1'b0);
        check_eq("s3_gap1", 32'(InstrValid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("s3_gap2", 32'(InstrValid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        check_eq("s3_valid", 32'(InstrValid), 32'd1);
        check_eq("s3_pc",    32'(InstrPC),    32'h0040);

        // Scenario 4: PC wrap
        step(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
        check_eq("s4_addr0", 32'(RomAddr), 32'hFF);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("s4_addr1", 32'(RomAddr), 32'h00);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("s4_addr2", 32'(RomAddr), 32'h01);
        check_eq("s4_pc0",   32'(InstrPC), 32'hFFFF);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("s4_pc1",   32'(InstrPC), 32'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("s4_pc2",   32'(InstrPC), 32'h0001);

        // Scenario 5: reset with full buffer and a read in flight
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("s5_valid", 32'(InstrValid), 32'd0);
        check_eq("s5_pc",    32'(RomAddr),    32'h00);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("s5_stale", 32'(InstrValid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("s5_first", 32'(InstrPC),    32'h0000);
        check_eq("s5_fval",  32'(InstrValid), 32'd1);

        // Scenario 6: pop coincident with redirect
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        popped_pc = InstrPC;
        step(1'b0, 1'b1, 1'b1, 16'h0010, 1'b1);
        check_eq("s6_flush", 32'(InstrValid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        check_eq("s6_next",  32'(InstrPC),    32'h0010);
        check_eq("s6_notdup", 32'(InstrPC == popped_pc), 32'd0);
        check_eq("s6_pops",  32'(obs_pops),   32'(model_pops));

        // Redirect while disabled: no read until Enable returns
        step(1'b0, 1'b0, 1'b1, 16'h0080, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check_eq("dis_addr",  32'(RomAddr),    32'h80);
        check_eq("dis_valid", 32'(InstrValid), 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 19) == 0),
                 16'($urandom),
                 ($urandom_range(0, 3) != 0));
        end
        check_eq("rand_pops", 32'(obs_pops), 32'(model_pops));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
